// File: rtl/procyon_rs_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : procyon_rs_sched_if
// Description : Bundle of dispatch, issue and per-entry status signals between
//               one reservation station bank and its scheduler.
//               master : drives flush, entry status, dispatch requests and FU
//                        stall; receives the scheduler strobes.
//               slave  : the scheduler itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface procyon_rs_sched_if #(
  parameter int OPTN_RS_DEPTH = 16,
  parameter int RS_IDX_WIDTH  = (OPTN_RS_DEPTH == 1) ? 1 : $clog2(OPTN_RS_DEPTH)
);

  // Flush and per-entry status
  logic                      i_flush;
  logic [0:OPTN_RS_DEPTH-1]  i_rs_entry_empty;
  logic [0:OPTN_RS_DEPTH-1]  i_rs_entry_ready;
  logic [RS_IDX_WIDTH-1:0]   i_rs_entry_age [0:OPTN_RS_DEPTH-1];

  // Dispatch side
  logic                      i_dispatch_reserve;
  logic                      i_dispatch_valid;
  logic                      o_rs_stall;
  logic [0:OPTN_RS_DEPTH-1]  o_reserve_en;
  logic [0:OPTN_RS_DEPTH-1]  o_dispatch_en;
  logic                      o_dispatching;

  // Issue side
  logic                      i_fu_stall;
  logic [0:OPTN_RS_DEPTH-1]  o_issue_en;
  logic                      o_issuing;
  logic [RS_IDX_WIDTH-1:0]   o_rs_issue_entry_age;
  logic                      o_issue_valid;
  logic [RS_IDX_WIDTH-1:0]   o_issue_idx;

  // Occupancy
  logic [RS_IDX_WIDTH:0]     o_rs_count;

  modport master (
    output i_flush, i_rs_entry_empty, i_rs_entry_ready, i_rs_entry_age,
    output i_dispatch_reserve, i_dispatch_valid, i_fu_stall,
    input  o_rs_stall, o_reserve_en, o_dispatch_en, o_dispatching,
    input  o_issue_en, o_issuing, o_rs_issue_entry_age, o_issue_valid,
    input  o_issue_idx, o_rs_count
  );

  modport slave (
    input  i_flush, i_rs_entry_empty, i_rs_entry_ready, i_rs_entry_age,
    input  i_dispatch_reserve, i_dispatch_valid, i_fu_stall,
    output o_rs_stall, o_reserve_en, o_dispatch_en, o_dispatching,
    output o_issue_en, o_issuing, o_rs_issue_entry_age, o_issue_valid,
    output o_issue_idx, o_rs_count
  );

endinterface
`default_nettype wire

// File: rtl/procyon_rs_sched.sv
`default_nettype none
// ============================================================================
// Module      : procyon_rs_sched
// Description : Scheduler for one reservation station bank. Picks the
//               lowest-index free entry for a dispatch reservation and holds
//               it until the payload arrives, selects the oldest ready entry
//               for issue, drives the age-update broadcast and tracks
//               occupancy.
// Ports       : clk    - clock
//               n_rst  - asynchronous active-low reset
//               rs_if  - procyon_rs_sched_if.slave (dispatch/issue/status)
// Config      : PCYN_RS_SCHED_ISSUE_PIPE_EN - when defined, o_issue_valid and
//               o_issue_idx are registered one cycle behind o_issue_en;
//               otherwise they are combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module procyon_rs_sched #(
  parameter int OPTN_RS_DEPTH = 16,
  parameter int RS_IDX_WIDTH  = (OPTN_RS_DEPTH == 1) ? 1 : $clog2(OPTN_RS_DEPTH)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  procyon_rs_sched_if.slave    rs_if
);

  localparam logic [RS_IDX_WIDTH:0] C_ONE   = (RS_IDX_WIDTH+1)'(1);
  localparam logic [RS_IDX_WIDTH:0] C_DEPTH = (RS_IDX_WIDTH+1)'(OPTN_RS_DEPTH);

  // Registered state
  logic                    rsv_valid_q, rsv_valid_d;
  logic [RS_IDX_WIDTH-1:0] rsv_idx_q,   rsv_idx_d;
  logic [RS_IDX_WIDTH:0]   count_q,     count_d;

  // Combinational selection results
  logic                    empty_found;
  logic [RS_IDX_WIDTH-1:0] empty_idx;
  logic                    best_found;
  logic [RS_IDX_WIDTH-1:0] best_idx;
  logic [RS_IDX_WIDTH-1:0] best_age;

  logic                    reserve_fire;
  logic                    dispatch_fire;
  logic                    issue_fire;

  logic [0:OPTN_RS_DEPTH-1] reserve_en;
  logic [0:OPTN_RS_DEPTH-1] dispatch_en;
  logic [0:OPTN_RS_DEPTH-1] issue_en;

  // Lowest-index free entry
  always_comb begin
    empty_found = 1'b0;
    empty_idx   = '0;
    for (int i = 0; i < OPTN_RS_DEPTH; i++) begin
      if (!empty_found && rs_if.i_rs_entry_empty[i]) begin
        empty_found = 1'b1;
        empty_idx   = RS_IDX_WIDTH'(i);
      end
    end
  end

  // Oldest ready entry. The strict greater-than keeps the earlier (lower)
  // index on an age tie because the scan runs upward.
  always_comb begin
    best_found = 1'b0;
    best_idx   = '0;
    best_age   = '0;
    for (int i = 0; i < OPTN_RS_DEPTH; i++) begin
      if (rs_if.i_rs_entry_ready[i] &&
          (!best_found || (rs_if.i_rs_entry_age[i] > best_age))) begin
        best_found = 1'b1;
        best_idx   = RS_IDX_WIDTH'(i);
        best_age   = rs_if.i_rs_entry_age[i];
      end
    end
  end

  assign reserve_fire  = rs_if.i_dispatch_reserve & ~rs_if.i_flush & empty_found;
  assign dispatch_fire = rs_if.i_dispatch_valid & rsv_valid_q & ~rs_if.i_flush;
  assign issue_fire    = ~rs_if.i_fu_stall & ~rs_if.i_flush & best_found;

  // One-hot strobes
  always_comb begin
    reserve_en  = '0;
    dispatch_en = '0;
    issue_en    = '0;
    if (reserve_fire) begin
      reserve_en[empty_idx] = 1'b1;
    end
    if (dispatch_fire) begin
      dispatch_en[rsv_idx_q] = 1'b1;
    end
    if (issue_fire) begin
      issue_en[best_idx] = 1'b1;
    end
  end

  // Reservation tracking and occupancy. A new reserve in the same cycle as a
  // dispatch keeps the reservation alive with the newly chosen index.
  always_comb begin
    rsv_valid_d = rsv_valid_q;
    rsv_idx_d   = rsv_idx_q;
    count_d     = count_q;

    if (reserve_fire) begin
      rsv_valid_d = 1'b1;
      rsv_idx_d   = empty_idx;
    end else if (dispatch_fire) begin
      rsv_valid_d = 1'b0;
    end

    case ({reserve_fire, issue_fire})
      2'b10:   count_d = count_q + C_ONE;
      2'b01:   count_d = count_q - C_ONE;
      default: count_d = count_q;
    endcase

    if (rs_if.i_flush) begin
      rsv_valid_d = 1'b0;
      count_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rsv_valid_q <= 1'b0;
      rsv_idx_q   <= '0;
      count_q     <= '0;
    end else begin
      rsv_valid_q <= rsv_valid_d;
      rsv_idx_q   <= rsv_idx_d;
      count_q     <= count_d;
    end
  end

  assign rs_if.o_rs_stall           = ~|rs_if.i_rs_entry_empty;
  assign rs_if.o_reserve_en         = reserve_en;
  assign rs_if.o_dispatch_en        = dispatch_en;
  assign rs_if.o_dispatching        = dispatch_fire;
  assign rs_if.o_issue_en           = issue_en;
  assign rs_if.o_issuing            = issue_fire;
  assign rs_if.o_rs_issue_entry_age = issue_fire ? best_age : '0;
  assign rs_if.o_rs_count           = count_q;

`ifdef PCYN_RS_SCHED_ISSUE_PIPE_EN
  logic                    issue_valid_q, issue_valid_d;
  logic [RS_IDX_WIDTH-1:0] issue_idx_q,   issue_idx_d;

  always_comb begin
    issue_valid_d = issue_fire;
    issue_idx_d   = issue_fire ? best_idx : issue_idx_q;
    if (rs_if.i_flush) begin
      issue_valid_d = 1'b0;
      issue_idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      issue_valid_q <= 1'b0;
      issue_idx_q   <= '0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
    end
  end

  assign rs_if.o_issue_valid = issue_valid_q;
  assign rs_if.o_issue_idx   = issue_idx_q;
`else
  assign rs_if.o_issue_valid = issue_fire;
  assign rs_if.o_issue_idx   = best_idx;
`endif

`ifndef SYNTHESIS
  // Occupancy must never wrap in either direction.
  a_count_no_overflow: assert property (@(posedge clk) disable iff (!n_rst)
    !(reserve_fire && !issue_fire && !rs_if.i_flush && (count_q == C_DEPTH)));
  a_count_no_underflow: assert property (@(posedge clk) disable iff (!n_rst)
    !(issue_fire && !reserve_fire && !rs_if.i_flush && (count_q == '0)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_procyon_rs_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_procyon_rs_sched
// Description : Directed scoreboard bench for procyon_rs_sched. Stimulus pushes
//               per-cycle status expectations plus dispatch and issue
//               expectations into queues; a negedge monitor pops and compares
//               whenever the DUT presents a strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_procyon_rs_sched;

  localparam int D = 16;
  localparam int W = 4;

  logic clk = 1'b0;
  logic n_rst;

  always #5 clk = ~clk;

  procyon_rs_sched_if #(.OPTN_RS_DEPTH(D), .RS_IDX_WIDTH(W)) rs_if ();

  procyon_rs_sched #(.OPTN_RS_DEPTH(D), .RS_IDX_WIDTH(W)) u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .rs_if (rs_if)
  );

  typedef struct packed {
    logic         stall;
    logic [W:0]   count;
    logic [0:D-1] rsv;
    logic         dispatching;
    logic         issuing;
    logic [W-1:0] idx;
  } st_t;

  typedef struct packed {
    logic [0:D-1] en;
    logic [W-1:0] age;
  } iss_t;

  st_t          st_q[$];
  iss_t         iss_q[$];
  logic [0:D-1] disp_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [0:D-1] oh(input int i);
    logic [0:D-1] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_ready();
    rs_if.i_rs_entry_ready = '0;
    for (int i = 0; i < D; i++) rs_if.i_rs_entry_age[i] = '0;
  endtask

  task automatic set_rdy(input int i, input int age);
    logic [31:0] a;
    a = age;
    rs_if.i_rs_entry_ready[i] = 1'b1;
    rs_if.i_rs_entry_age[i]   = a[W-1:0];
  endtask

  task automatic push_iss(input int i, input int age);
    iss_t e;
    logic [31:0] a;
    a     = age;
    e.en  = oh(i);
    e.age = a[W-1:0];
    iss_q.push_back(e);
  endtask

  // Push the expected status for the current cycle, then advance one cycle.
  task automatic step(input logic stall, input int cnt, input logic [0:D-1] rsv,
                      input logic disp, input logic iss, input int idx);
    st_t s;
    logic [31:0] c;
    logic [31:0] x;
    c = cnt;
    x = idx;
    s.stall       = stall;
    s.count       = c[W:0];
    s.rsv         = rsv;
    s.dispatching = disp;
    s.issuing     = iss;
    s.idx         = x[W-1:0];
    st_q.push_back(s);
    @(posedge clk);
    #1;
  endtask

  // Monitor
  st_t          m_st;
  iss_t         m_iss;
  logic [0:D-1] m_disp;
  logic         prev_iss = 1'b0;
  logic [W-1:0] prev_idx = '0;
  logic         exp_iv;
  logic [W-1:0] exp_idx;

  always @(negedge clk) begin
    if (st_q.size() != 0) begin
      m_st = st_q.pop_front();
      chk("rs_stall",    32'(rs_if.o_rs_stall),    32'(m_st.stall));
      chk("rs_count",    32'(rs_if.o_rs_count),    32'(m_st.count));
      chk("reserve_en",  32'(rs_if.o_reserve_en),  32'(m_st.rsv));
      chk("dispatching", 32'(rs_if.o_dispatching), 32'(m_st.dispatching));
      chk("issuing",     32'(rs_if.o_issuing),     32'(m_st.issuing));
`ifdef PCYN_RS_SCHED_ISSUE_PIPE_EN
      exp_iv  = prev_iss;
      exp_idx = prev_idx;
`else
      exp_iv  = m_st.issuing;
      exp_idx = m_st.idx;
`endif
      chk("issue_valid", 32'(rs_if.o_issue_valid), 32'(exp_iv));
      if (exp_iv) chk("issue_idx", 32'(rs_if.o_issue_idx), 32'(exp_idx));
      prev_iss = m_st.issuing;
      prev_idx = m_st.idx;
    end

    if (rs_if.o_dispatching) begin
      if (disp_q.size() == 0) begin
        chk("unexpected_dispatch", 32'(rs_if.o_dispatch_en), 32'h0);
      end else begin
        m_disp = disp_q.pop_front();
        chk("dispatch_en", 32'(rs_if.o_dispatch_en), 32'(m_disp));
      end
    end else begin
      chk("dispatch_en_idle", 32'(rs_if.o_dispatch_en), 32'h0);
    end

    if (rs_if.o_issuing) begin
      if (iss_q.size() == 0) begin
        chk("unexpected_issue", 32'(rs_if.o_issue_en), 32'h0);
      end else begin
        m_iss = iss_q.pop_front();
        chk("issue_en",  32'(rs_if.o_issue_en),           32'(m_iss.en));
        chk("issue_age", 32'(rs_if.o_rs_issue_entry_age), 32'(m_iss.age));
      end
    end else begin
      chk("issue_en_idle",  32'(rs_if.o_issue_en),           32'h0);
      chk("issue_age_idle", 32'(rs_if.o_rs_issue_entry_age), 32'h0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected < 100000", $time);
    $fatal(1);
  end

  initial begin
    n_rst                    = 1'b0;
    rs_if.i_flush            = 1'b0;
    rs_if.i_dispatch_reserve = 1'b0;
    rs_if.i_dispatch_valid   = 1'b0;
    rs_if.i_fu_stall         = 1'b0;
    rs_if.i_rs_entry_empty   = '1;
    clr_ready();
    @(posedge clk);
    #1;

    // Reset state
    step(0, 0, '0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0);

    // Reset then reserve entry 0, dispatch next cycle
    n_rst = 1'b1;
    rs_if.i_dispatch_reserve = 1'b1;
    step(0, 0, oh(0), 0, 0, 0);
    rs_if.i_dispatch_reserve = 1'b0;
    rs_if.i_dispatch_valid   = 1'b1;
    rs_if.i_rs_entry_empty[0] = 1'b0;
    disp_q.push_back(oh(0));
    step(0, 1, '0, 1, 0, 0);

    // Fill the remaining entries, lowest free first
    rs_if.i_dispatch_valid   = 1'b0;
    rs_if.i_dispatch_reserve = 1'b1;
    for (int k = 1; k < D; k++) begin
      for (int i = 0; i < D; i++) rs_if.i_rs_entry_empty[i] = (i >= k);
      step(0, k, oh(k), 0, 0, 0);
    end

    // Full bank: stall, no reserve, issue entry 4 in the same cycle
    rs_if.i_rs_entry_empty = '0;
    set_rdy(4, 0);
    push_iss(4, 0);
    step(1, 16, '0, 0, 1, 4);

    // Oldest-first: 2/5/9 with ages 3/7/1 -> entry 5
    rs_if.i_dispatch_reserve = 1'b0;
    clr_ready();
    set_rdy(2, 3);
    set_rdy(5, 7);
    set_rdy(9, 1);
    push_iss(5, 7);
    step(1, 15, '0, 0, 1, 5);

    // FU backpressure blocks issue
    rs_if.i_fu_stall = 1'b1;
    step(1, 14, '0, 0, 0, 0);

    // Age tie -> lowest index
    rs_if.i_fu_stall = 1'b0;
    clr_ready();
    set_rdy(3, 6);
    set_rdy(7, 6);
    push_iss(3, 6);
    step(1, 14, '0, 0, 1, 3);

    // Simultaneous reserve (entry 3) and issue (entry 8): count unchanged
    clr_ready();
    set_rdy(8, 2);
    rs_if.i_rs_entry_empty    = '0;
    rs_if.i_rs_entry_empty[3] = 1'b1;
    rs_if.i_dispatch_reserve  = 1'b1;
    push_iss(8, 2);
    step(0, 13, oh(3), 0, 1, 8);

    // Back-to-back: dispatch entry 3 while reserving entry 10
    clr_ready();
    rs_if.i_rs_entry_empty     = '0;
    rs_if.i_rs_entry_empty[10] = 1'b1;
    rs_if.i_dispatch_valid     = 1'b1;
    disp_q.push_back(oh(3));
    step(0, 13, oh(10), 1, 0, 0);

    // Dispatch entry 10
    rs_if.i_rs_entry_empty   = '0;
    rs_if.i_dispatch_reserve = 1'b0;
    disp_q.push_back(oh(10));
    step(1, 14, '0, 1, 0, 0);

    // Reserve entry 11, then flush with dispatch and a ready entry present
    rs_if.i_dispatch_valid     = 1'b0;
    rs_if.i_rs_entry_empty[11] = 1'b1;
    rs_if.i_dispatch_reserve   = 1'b1;
    step(0, 14, oh(11), 0, 0, 0);
    rs_if.i_flush              = 1'b1;
    rs_if.i_dispatch_valid     = 1'b1;
    rs_if.i_rs_entry_empty     = '0;
    rs_if.i_rs_entry_empty[12] = 1'b1;
    set_rdy(1, 5);
    step(0, 15, '0, 0, 0, 0);

    // Dispatch after the flushed reservation is ignored; count cleared
    rs_if.i_flush            = 1'b0;
    clr_ready();
    rs_if.i_dispatch_reserve = 1'b0;
    rs_if.i_rs_entry_empty   = '1;
    step(0, 0, '0, 0, 0, 0);
    rs_if.i_dispatch_valid   = 1'b0;
    step(0, 0, '0, 0, 0, 0);

    @(negedge clk);
    chk("status_queue_drained",   32'(st_q.size()),   32'h0);
    chk("issue_queue_drained",    32'(iss_q.size()),  32'h0);
    chk("dispatch_queue_drained", 32'(disp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/procyon_rs_sched.md
# procyon_rs_sched

Scheduler and controller for one reservation station bank of `OPTN_RS_DEPTH` procyon_rs_entry instances. It picks a free entry for each dispatch reservation and holds that choice until the dispatch data arrives one cycle later. It selects the oldest ready entry for issue under functional-unit backpressure and drives the shared age-update broadcast (`dispatching`, `issuing`, issue entry age) to every entry. It also keeps an occupancy count and produces the dispatch-side stall.

## Interface
Parameters:
- `OPTN_RS_DEPTH`, 16, number of entries.
- `RS_IDX_WIDTH`, `OPTN_RS_DEPTH == 1 ? 1 : $clog2(OPTN_RS_DEPTH)`, entry index and age width.

Ports:
- `clk`  in  1  clock; single clock domain.
- `n_rst`  in  1  asynchronous, active-low reset.
- `i_flush`  in  1  pipeline flush.
- `i_rs_entry_empty`  in  [0:OPTN_RS_DEPTH-1]×1  per-entry empty.
- `i_rs_entry_ready`  in  [0:OPTN_RS_DEPTH-1]×1  per-entry ready to issue.
- `i_rs_entry_age`  in  [0:OPTN_RS_DEPTH-1]×RS_IDX_WIDTH  per-entry age; larger means older.
- `i_dispatch_reserve`  in  1  dispatcher requests an entry this cycle.
- `i_dispatch_valid`  in  1  dispatch payload is present this cycle.
- `o_rs_stall`  out  1  no free entry.
- `o_reserve_en`  out  [0:OPTN_RS_DEPTH-1]×1  one-hot reserve strobe.
- `o_dispatch_en`  out  [0:OPTN_RS_DEPTH-1]×1  one-hot dispatch strobe.
- `o_dispatching`  out  1  broadcast to all entries.
- `i_fu_stall`  in  1  functional unit cannot accept an op.
- `o_issue_en`  out  [0:OPTN_RS_DEPTH-1]×1  one-hot issue strobe.
- `o_issuing`  out  1  broadcast to all entries.
- `o_rs_issue_entry_age`  out  RS_IDX_WIDTH  age of the issuing entry.
- `o_issue_valid`  out  1  issue index valid toward the FU operand mux.
- `o_issue_idx`  out  RS_IDX_WIDTH  index of the issued entry.
- `o_rs_count`  out  RS_IDX_WIDTH+1  number of occupied entries.

## Operation
**Reserve**
- Condition: `i_dispatch_reserve & ~i_flush` and at least one `i_rs_entry_empty` is set.
- `o_reserve_en` is one-hot on the lowest-index empty entry (combinational).
- The chosen index is captured in `rsv_idx_r` and `rsv_valid_r` is set.
- `o_rs_stall = ~|i_rs_entry_empty`. It is combinational and does not credit an entry issuing in the same cycle.

**Dispatch**
- Condition: `i_dispatch_valid & rsv_valid_r & ~i_flush`.
- `o_dispatch_en[rsv_idx_r]` = 1 and `o_dispatching` = 1.
- `rsv_valid_r` clears unless a new reserve occurs in the same cycle.
- If `i_dispatch_valid` arrives without `rsv_valid_r`, it is ignored and all dispatch outputs stay 0.

**Issue select**
- Candidates are entries with `i_rs_entry_ready` set.
- Winner is the candidate with the maximum `i_rs_entry_age`; ties go to the lowest index.
- When `~i_fu_stall & ~i_flush` and any candidate exists:
  - `o_issue_en` is one-hot on the winner;
  - `o_issuing` = 1;
  - `o_rs_issue_entry_age` = the winner's age.
- Otherwise `o_issue_en` is all-zero, `o_issuing` = 0, and `o_rs_issue_entry_age` = 0.

**Occupancy**
- `o_rs_count` next = count + reserve − issue. A simultaneous reserve and issue nets zero.
- Saturation is an assertion error: no increment above `OPTN_RS_DEPTH`, no decrement below 0.

**Flush**
- All strobes are forced to 0 in the flush cycle.
- On the next edge: `rsv_valid_r` = 0, `o_issue_valid` = 0, `o_rs_count` = 0.
- A dispatch that arrives after a flushed reservation is ignored.

## Timing
- Reset values: `rsv_valid_r`=0, `rsv_idx_r`=0, `o_issue_valid`=0, `o_issue_idx`=0, `o_rs_count`=0.
- Combinational outputs under reset inputs: `o_reserve_en`, `o_dispatch_en` and `o_issue_en` all-zero; `o_dispatching`=0, `o_issuing`=0; `o_rs_stall` = `~|i_rs_entry_empty`.
- Reserve in cycle N; `o_dispatch_en` is available in cycle N+1 at the earliest. `rsv_valid_r` persists until a dispatch or a flush consumes it.
- Back-to-back: reserve in N+1 together with dispatch in N+1 is legal. `rsv_idx_r` updates to the new index.
- A reserved-but-undispatched entry is neither empty nor ready, so it is never reselected and never issued.
- Issue strobes are combinational in the same cycle as the inputs.
- Reset may assert in any state. All registers clear asynchronously, with no partial-state recovery.

## Configuration
- Macro: `PCYN_RS_SCHED_ISSUE_PIPE_EN`.
- Defined: `o_issue_valid` and `o_issue_idx` are registered. They follow `o_issue_en` by one cycle and are cleared by a flush.
- Undefined: `o_issue_valid = o_issuing` and `o_issue_idx` = the winner index, both combinational in the same cycle.

## Test plan
- **Reset then reserve:** reset; all entries empty; `i_dispatch_reserve`=1 → `o_reserve_en`[0]=1, `o_rs_count`=1 next cycle; `i_dispatch_valid` next cycle → `o_dispatch_en`[0]=1, `o_dispatching`=1.
- **Oldest-first issue:** entries 2, 5 and 9 ready with ages 3, 7 and 1 → `o_issue_en`[5]=1, `o_rs_issue_entry_age`=7. With `i_fu_stall`=1 → no issue, `o_issuing`=0.
- **Full bank:** 16 occupied, `i_rs_entry_empty`=0 → `o_rs_stall`=1, `o_reserve_en`=0. Same cycle issue of entry 4 → `o_rs_count` 16→15; `o_rs_stall` stays 1 this cycle.
- **Simultaneous reserve and issue:** count 6, reserve entry 3 and issue entry 8 in the same cycle → count stays 6; `o_dispatching` next cycle only.
- **Flush mid-reservation:** reserve in N, `i_flush` in N+1 together with `i_dispatch_valid` → `o_dispatch_en`=0; then `rsv_valid_r`=0 and `o_rs_count`=0.
- **Stray dispatch and pipe macro:** `i_dispatch_valid` with no reservation → no strobes. With `PCYN_RS_SCHED_ISSUE_PIPE_EN` defined, issue of entry 5 in N → `o_issue_valid`=1, `o_issue_idx`=5 in N+1.
